// File: rtl/huffman_pkg.sv
// Shared constants and state encoding for the bit-serial Huffman decoder.
package huffman_pkg;
    localparam int NSYM   = 6;
    localparam int CODE_W = 8;
    localparam int CNT_W  = 16;
    localparam int LEN_W  = $clog2(CODE_W + 1);
    localparam int IDX_W  = 3;
    localparam logic [7:0] GRAY_BASE = 8'd1;

    typedef enum logic [1:0] {IDLE, RUN, ERR} state_t;
endpackage

// File: rtl/huffman_match.sv
// Combinational code-table lookup: finds the symbol whose code exactly covers
// the accumulated bits. Lowest index wins when the table is not prefix-free.
module huffman_match
    import huffman_pkg::*;
#(
    parameter int CW = CODE_W,
    parameter int LW = LEN_W
) (
    input  logic [CW-1:0]            acc_n,
    input  logic [LW-1:0]            len_n,
    input  logic [NSYM-1:0][CW-1:0]  hc,
    input  logic [NSYM-1:0][CW-1:0]  m,
    output logic                     hit,
    output logic [IDX_W-1:0]         idx
);
    logic [CW:0] full;

    always_comb begin
        full = ({{CW{1'b0}}, 1'b1} << len_n) - 1'b1;
        hit  = 1'b0;
        idx  = '0;
        // Walk downwards so the lowest matching index is the one left standing.
        for (int i = NSYM - 1; i >= 0; i--) begin
            if (({1'b0, m[i]} == full) && ((acc_n & m[i]) == hc[i])) begin
                hit = 1'b1;
                idx = IDX_W'(i);
            end
        end
    end
endmodule

// File: rtl/huffman_decoder.sv
// Bit-serial Huffman decoder: shifts code bits into an accumulator and emits
// one gray value per completed code word through a valid/ready output register.
module huffman_decoder
    import huffman_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              table_valid,
    input  logic [CODE_W-1:0] HC1,
    input  logic [CODE_W-1:0] HC2,
    input  logic [CODE_W-1:0] HC3,
    input  logic [CODE_W-1:0] HC4,
    input  logic [CODE_W-1:0] HC5,
    input  logic [CODE_W-1:0] HC6,
    input  logic [CODE_W-1:0] M1,
    input  logic [CODE_W-1:0] M2,
    input  logic [CODE_W-1:0] M3,
    input  logic [CODE_W-1:0] M4,
    input  logic [CODE_W-1:0] M5,
    input  logic [CODE_W-1:0] M6,
    input  logic              bit_valid,
    input  logic              bit_in,
    output logic              bit_ready,
    output logic              sym_valid,
    output logic [7:0]        sym_data,
    input  logic              sym_ready,
    output logic [CNT_W-1:0]  sym_count,
    output logic              err
);
    state_t                        state, state_next;
    logic [NSYM-1:0][CODE_W-1:0]   hc_q, m_q;
    logic [CODE_W-1:0]             acc, acc_n;
    logic [LEN_W-1:0]              len, len_n;
    logic                          accept, hit, overflow, handoff;
    logic [IDX_W-1:0]              idx;

    assign bit_ready = (state == RUN) && (!sym_valid || sym_ready);
    // A table load wins over any bit offered in the same cycle.
    assign accept    = bit_valid && bit_ready && !table_valid;
    assign acc_n     = {acc[CODE_W-2:0], bit_in};
    assign len_n     = len + 1'b1;
    assign overflow  = accept && !hit && (len_n == LEN_W'(CODE_W));
    assign handoff   = sym_valid && sym_ready;
    assign err       = (state == ERR);

    huffman_match u_match (
        .acc_n (acc_n),
        .len_n (len_n),
        .hc    (hc_q),
        .m     (m_q),
        .hit   (hit),
        .idx   (idx)
    );

    always_comb begin
        state_next = state;
        if (table_valid)
            state_next = RUN;
        else if (state == RUN && overflow)
            state_next = ERR;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            state <= IDLE;
        else
            state <= state_next;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hc_q      <= '0;
            m_q       <= '0;
            acc       <= '0;
            len       <= '0;
            sym_valid <= 1'b0;
            sym_data  <= '0;
            sym_count <= '0;
        end else if (table_valid) begin
            hc_q      <= {HC6, HC5, HC4, HC3, HC2, HC1};
            m_q       <= {M6, M5, M4, M3, M2, M1};
            acc       <= '0;
            len       <= '0;
            sym_valid <= 1'b0;
            sym_count <= '0;
        end else begin
            if (handoff) begin
                sym_count <= sym_count + 1'b1;
                sym_valid <= 1'b0;
            end
            if (accept) begin
                if (hit) begin
                    // A match in the handoff cycle keeps the output full.
                    sym_valid <= 1'b1;
                    sym_data  <= GRAY_BASE + 8'(idx);
                    acc       <= '0;
                    len       <= '0;
                end else if (!overflow) begin
                    acc <= acc_n;
                    len <= len_n;
                end
            end
        end
    end
endmodule

// File: tb/tb_huffman_decoder.sv
// Directed bench for huffman_decoder using the six-symbol table T.
module tb_huffman_decoder;
    import huffman_pkg::*;

    logic              clk, reset, table_valid, bit_valid, bit_in, sym_ready;
    logic              bit_ready, sym_valid, err;
    logic [7:0]        sym_data;
    logic [CNT_W-1:0]  sym_count;
    logic [CODE_W-1:0] hc [NSYM];
    logic [CODE_W-1:0] m  [NSYM];

    int errors = 0;
    int checks = 0;
    bit rand_rdy = 0;
    logic [7:0] got [$];
    logic [7:0] exp_q [$];

    // Table T: code words and lengths, MSB of each code first on the wire.
    localparam logic [CODE_W-1:0] T_HC [NSYM] = '{8'h01, 8'h01, 8'h00, 8'h02, 8'h06, 8'h07};
    localparam int                T_LEN[NSYM] = '{1, 2, 3, 4, 5, 5};

    huffman_decoder dut (
        .clk(clk), .reset(reset), .table_valid(table_valid),
        .HC1(hc[0]), .HC2(hc[1]), .HC3(hc[2]), .HC4(hc[3]), .HC5(hc[4]), .HC6(hc[5]),
        .M1(m[0]), .M2(m[1]), .M3(m[2]), .M4(m[3]), .M5(m[4]), .M6(m[5]),
        .bit_valid(bit_valid), .bit_in(bit_in), .bit_ready(bit_ready),
        .sym_valid(sym_valid), .sym_data(sym_data), .sym_ready(sym_ready),
        .sym_count(sym_count), .err(err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk)
        if (!reset && sym_valid && sym_ready) got.push_back(sym_data);

    task automatic set_table_t();
        for (int i = 0; i < NSYM; i++) begin
            hc[i] = T_HC[i];
            m[i]  = CODE_W'((1 << T_LEN[i]) - 1);
        end
    endtask

    task automatic load_table();
        table_valid = 1'b1;
        @(posedge clk); #1;
        table_valid = 1'b0;
        got.delete();
    endtask

    task automatic push_bit(input logic b);
        int n;
        n = 0;
        bit_valid = 1'b1;
        bit_in    = b;
        forever begin
            if (rand_rdy) sym_ready = ($urandom_range(0, 3) != 0);
            #1;
            if (bit_ready || n == 64) break;
            @(posedge clk); #1;
            n++;
        end
        if (n == 64) begin
            checks++; errors++;
            $display("FAIL push_bit_timeout: bit_ready stayed 0 for 64 cycles, required 1");
        end
        @(posedge clk); #1;
        bit_valid = 1'b0;
    endtask

    task automatic test_reset();
        #3;
        checks++; if (bit_ready !== 1'b0) begin errors++; $display("FAIL reset_bit_ready: got %b want 0", bit_ready); end
        checks++; if (sym_valid !== 1'b0) begin errors++; $display("FAIL reset_sym_valid: got %b want 0", sym_valid); end
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL reset_err: got %b want 0", err); end
        checks++; if (sym_data !== 8'd0) begin errors++; $display("FAIL reset_sym_data: got %0d want 0", sym_data); end
        checks++; if (sym_count !== '0) begin errors++; $display("FAIL reset_sym_count: got %0d want 0", sym_count); end
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk); #1;
        checks++; if (bit_ready !== 1'b0) begin errors++; $display("FAIL idle_bit_ready: got %b want 0", bit_ready); end
    endtask

    task automatic test_basic_stream();
        logic       bits [6]  = '{1, 0, 1, 0, 0, 0};
        logic       ev   [6]  = '{1, 0, 1, 0, 0, 1};
        logic [7:0] ed   [6]  = '{1, 0, 2, 0, 0, 3};
        set_table_t();
        sym_ready = 1'b1;
        load_table();
        checks++; if (bit_ready !== 1'b1) begin errors++; $display("FAIL run_bit_ready: got %b want 1", bit_ready); end
        for (int i = 0; i < 6; i++) begin
            push_bit(bits[i]);
            checks++;
            if (sym_valid !== ev[i] || (ev[i] && sym_data !== ed[i])) begin
                errors++;
                $display("FAIL basic_bit%0d: valid=%b data=%0d want valid=%b data=%0d", i, sym_valid, sym_data, ev[i], ed[i]);
            end
        end
        @(posedge clk); #1;
        checks++; if (sym_count !== 16'd3) begin errors++; $display("FAIL basic_count: got %0d want 3", sym_count); end
        checks++; if (sym_valid !== 1'b0) begin errors++; $display("FAIL basic_drain: sym_valid=%b want 0", sym_valid); end
    endtask

    task automatic test_back_to_back();
        logic       first [4]  = '{0, 0, 1, 0};
        logic       rest  [10] = '{0, 0, 1, 1, 0, 0, 0, 1, 1, 1};
        logic [7:0] want  [3]  = '{4, 5, 6};
        sym_ready = 1'b0;
        load_table();
        for (int i = 0; i < 4; i++) push_bit(first[i]);
        checks++; if (sym_valid !== 1'b1 || sym_data !== 8'd4) begin errors++; $display("FAIL bp_first: valid=%b data=%0d want 1/4", sym_valid, sym_data); end
        bit_valid = 1'b1; bit_in = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(posedge clk); #1;
            checks++;
            if (bit_ready !== 1'b0 || sym_valid !== 1'b1 || sym_data !== 8'd4) begin
                errors++;
                $display("FAIL bp_hold%0d: ready=%b valid=%b data=%0d want 0/1/4", c, bit_ready, sym_valid, sym_data);
            end
        end
        bit_valid = 1'b0;
        sym_ready = 1'b1;
        for (int i = 0; i < 10; i++) push_bit(rest[i]);
        repeat (2) @(posedge clk);
        #1;
        checks++; if (got.size() !== 3) begin errors++; $display("FAIL bp_size: got %0d symbols want 3", got.size()); end
        for (int i = 0; i < 3 && i < got.size(); i++) begin
            checks++; if (got[i] !== want[i]) begin errors++; $display("FAIL bp_sym%0d: got %0d want %0d", i, got[i], want[i]); end
        end
        checks++; if (sym_count !== 16'd3) begin errors++; $display("FAIL bp_count: got %0d want 3", sym_count); end
    endtask

    task automatic test_overflow();
        logic bits [8] = '{0, 0, 1, 1, 1, 0, 0, 0};
        m[5] = '0;
        load_table();
        for (int i = 0; i < 8; i++) begin
            push_bit(bits[i]);
            checks++; if (sym_valid !== 1'b0) begin errors++; $display("FAIL ovf_valid%0d: got %b want 0", i, sym_valid); end
        end
        checks++; if (err !== 1'b1) begin errors++; $display("FAIL ovf_err: got %b want 1", err); end
        checks++; if (bit_ready !== 1'b0) begin errors++; $display("FAIL ovf_ready: got %b want 0", bit_ready); end
        set_table_t();
        load_table();
        checks++; if (err !== 1'b0 || bit_ready !== 1'b1) begin errors++; $display("FAIL ovf_reload: err=%b ready=%b want 0/1", err, bit_ready); end
    endtask

    task automatic test_load_drops_bit();
        load_table();
        push_bit(1'b0);
        push_bit(1'b0);
        table_valid = 1'b1; bit_valid = 1'b1; bit_in = 1'b1;
        @(posedge clk); #1;
        table_valid = 1'b0; bit_valid = 1'b0;
        got.delete();
        checks++; if (sym_valid !== 1'b0) begin errors++; $display("FAIL drop_valid: got %b want 0", sym_valid); end
        push_bit(1'b1);
        checks++; if (sym_valid !== 1'b1 || sym_data !== 8'd1) begin errors++; $display("FAIL drop_sym: valid=%b data=%0d want 1/1", sym_valid, sym_data); end
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid();
        push_bit(1'b0); push_bit(1'b0); push_bit(1'b1);
        reset = 1'b1;
        #1;
        checks++;
        if (bit_ready !== 1'b0 || sym_valid !== 1'b0 || err !== 1'b0 || sym_data !== 8'd0 || sym_count !== '0) begin
            errors++;
            $display("FAIL midreset_outputs: ready=%b valid=%b err=%b data=%0d count=%0d want all 0", bit_ready, sym_valid, err, sym_data, sym_count);
        end
        @(posedge clk); #1;
        reset = 1'b0;
        bit_valid = 1'b1; bit_in = 1'b1;
        repeat (2) begin
            @(posedge clk); #1;
            checks++; if (bit_ready !== 1'b0 || sym_valid !== 1'b0) begin errors++; $display("FAIL midreset_idle: ready=%b valid=%b want 0/0", bit_ready, sym_valid); end
        end
        bit_valid = 1'b0;
    endtask

    task automatic test_loopback();
        int v, bad;
        load_table();
        exp_q.delete();
        rand_rdy = 1;
        for (int s = 0; s < 100; s++) begin
            v = $urandom_range(1, 6);
            exp_q.push_back(8'(v));
            for (int k = T_LEN[v-1] - 1; k >= 0; k--) push_bit(T_HC[v-1][k]);
        end
        rand_rdy = 0;
        sym_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (got.size() !== 100) begin errors++; $display("FAIL loop_size: got %0d symbols want 100", got.size()); end
        bad = 0;
        for (int i = 0; i < 100 && i < got.size(); i++)
            if (got[i] !== exp_q[i]) bad++;
        checks++; if (bad != 0) begin errors++; $display("FAIL loop_data: %0d symbols differ, want 0", bad); end
        checks++; if (sym_count !== 16'd100) begin errors++; $display("FAIL loop_count: got %0d want 100", sym_count); end
    endtask

    initial begin
        reset = 1'b1; table_valid = 1'b0; bit_valid = 1'b0; bit_in = 1'b0; sym_ready = 1'b0;
        set_table_t();
        test_reset();
        test_basic_stream();
        test_back_to_back();
        test_overflow();
        test_load_drops_bit();
        test_reset_mid();
        test_loopback();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
